// File: rtl/mem_map_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_map_tracker_if
// Brief    : Write/lookup/flush bundle between the RAM agents and the tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_map_tracker_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = 2
);
    logic                             flush;
    logic                             ready;
    logic [NB_WRAGENT-1:0]            wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr;
    logic [NB_RDAGENT-1:0]            rden;
    logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr;
    logic [NB_RDAGENT-1:0]            rdvalid;
    logic [NB_RDAGENT-1:0]            rdhit;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select;

    modport master (
        output flush, wren, wraddr, rden, rdaddr,
        input  ready, rdvalid, rdhit, bank_select
    );

    modport slave (
        input  flush, wren, wraddr, rden, rdaddr,
        output ready, rdvalid, rdhit, bank_select
    );
endinterface
`default_nettype wire

// File: rtl/mem_map_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mem_map_tracker
// Brief    : Shared last-writer table with pipelined bypassed lookups and a
//            flush sweep that re-initialises every row.
// Revision : 1.0 - initial release
// ============================================================================
module mem_map_tracker #(
    parameter int ADDR_WIDTH      = 8,
    parameter int RAM_DEPTH       = 2**ADDR_WIDTH,
    parameter int NB_WRAGENT      = 2,
    parameter int NB_RDAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int RD_LATENCY      = 1,
    parameter int IDX_WIDTH       = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int SELECT_WIDTH    = IDX_WIDTH + WRITE_COLLISION
) (
    input  logic             aclk,
    input  logic             aresetn,
    mem_map_tracker_if.slave bus
);
    // Entry layout: {written, collision, idx}
    localparam int                    ENT_W    = IDX_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [0:0]            ST_SWEEP = 1'b0;
    localparam logic [0:0]            ST_IDLE  = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ENT_W-1:0]      r_table [RAM_DEPTH];

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_wraddr [NB_WRAGENT];
    logic [NB_WRAGENT-1:0] w_wr_act;
    logic [NB_WRAGENT-1:0] w_wr_win;
    logic [NB_WRAGENT-1:0] w_wr_coll;
    logic [ENT_W-1:0]      w_wr_ent [NB_WRAGENT];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));
    endfunction

    assign bus.ready = (r_state == ST_IDLE);
    // The flush cycle itself is already closed to traffic.
    assign w_accept  = bus.ready && !bus.flush;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
        end else if (bus.flush) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
        end else if (r_state == ST_SWEEP) begin
            if (r_ptr == LAST_PTR) begin
                r_state <= ST_IDLE;
                r_ptr   <= '0;
            end else begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    for (genvar a = 0; a < NB_WRAGENT; a++) begin : g_wr
        assign w_wraddr[a] = bus.wraddr[a*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wr_act[a] = bus.wren[a] && w_accept && in_range(w_wraddr[a]);
    end

    // Only the lowest-index agent on an address writes; any higher-index
    // agent on the same address marks the collision.
    always_comb begin
        for (int a = 0; a < NB_WRAGENT; a++) begin
            w_wr_win[a]  = w_wr_act[a];
            w_wr_coll[a] = 1'b0;
            for (int j = 0; j < NB_WRAGENT; j++) begin
                if ((j != a) && w_wr_act[j] && (w_wraddr[j] == w_wraddr[a])) begin
                    w_wr_coll[a] = 1'b1;
                    if (j < a) begin
                        w_wr_win[a] = 1'b0;
                    end
                end
            end
            w_wr_ent[a] = {1'b1, w_wr_coll[a] & (WRITE_COLLISION != 0), IDX_WIDTH'(a)};
        end
    end

    always_ff @(posedge aclk) begin
        if (r_state == ST_SWEEP) begin
            r_table[r_ptr] <= '0;
        end else begin
            for (int a = 0; a < NB_WRAGENT; a++) begin
                if (w_wr_win[a]) begin
                    r_table[w_wraddr[a]] <= w_wr_ent[a];
                end
            end
        end
    end

    for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0]   w_addr;
        logic [ENT_W-1:0]        w_ent;
        logic [SELECT_WIDTH-1:0] w_sel;
        logic                    w_req;
        logic                    r_vld1;
        logic                    r_hit1;
        logic [SELECT_WIDTH-1:0] r_sel1;

        assign w_addr = bus.rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_req  = bus.rden[r] && w_accept;

        // Downward scan so the lowest-index matching writer (the winner) is kept.
        always_comb begin
            w_ent = in_range(w_addr) ? r_table[w_addr] : '0;
            for (int a = NB_WRAGENT - 1; a >= 0; a--) begin
                if (w_wr_act[a] && (w_wraddr[a] == w_addr)) begin
                    w_ent = w_wr_ent[a];
                end
            end
        end

        if (WRITE_COLLISION != 0) begin : g_sel_coll
            assign w_sel = w_ent[ENT_W-2:0];
        end else begin : g_sel_idx
            assign w_sel = w_ent[IDX_WIDTH-1:0];
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_vld1 <= 1'b0;
                r_hit1 <= 1'b0;
                r_sel1 <= '0;
            end else begin
                r_vld1 <= w_req;
                if (w_req) begin
                    r_hit1 <= w_ent[ENT_W-1];
                    r_sel1 <= w_sel;
                end
            end
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic                    r_vld2;
            logic                    r_hit2;
            logic [SELECT_WIDTH-1:0] r_sel2;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_vld2 <= 1'b0;
                    r_hit2 <= 1'b0;
                    r_sel2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_hit2 <= r_hit1;
                        r_sel2 <= r_sel1;
                    end
                end
            end

            assign bus.rdvalid[r]                                     = r_vld2;
            assign bus.rdhit[r]                                       = r_hit2;
            assign bus.bank_select[r*SELECT_WIDTH +: SELECT_WIDTH]    = r_sel2;
        end else begin : g_lat1
            assign bus.rdvalid[r]                                     = r_vld1;
            assign bus.rdhit[r]                                       = r_hit1;
            assign bus.bank_select[r*SELECT_WIDTH +: SELECT_WIDTH]    = r_sel1;
        end
    end
endmodule
`default_nettype wire
